timer_peripheral: RTL and testbench

Memory-mapped timer/IO peripheral that sits directly downstream of the single-cycle CPU data path. It occupies the 0x4000_0000 address window and owns a reloadable interval timer with interrupt, a free-running system tick, the LED, switch and 7-segment registers. It returns read data to the CPU write-back mux and drives the CPU interrupt request.

---
 rtl/timer_peripheral.sv | 184 ++++++++++++++++++
 tb/tb_timer_peripheral.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_peripheral.sv
// timer_peripheral
// Memory-mapped timer / IO block in the 0x4xxx_xxxx window of the
// single-cycle CPU. Holds a reloadable interval timer (TH/TL/TCON) with
// interrupt, a free-running system tick, and the LED, switch and
// 7-segment registers.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   MemRead     CPU load strobe
//   MemWrite    CPU store strobe
//   Address     byte address, [31:28]==4'h4 selects this block, [4:2] = word
//   Write_data  store data
//   Read_data   combinational load data (0 when not selected)
//   led         LED register
//   switch      board switches (read-only register)
//   digi        7-segment register, active-high
//   irqout      interrupt request = irq_en & irq_status
//
// Register map (word offset Address[4:2])
//   0 TH | 1 TL | 2 TCON{status,en,run} | 3 LED | 4 SWITCH | 5 DIGI
//   6 SYSTICK | 7 reads 0

module timer_peripheral #(
   parameter int PRESCALE   = 1,
   parameter int SYSTICK_EN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic [7:0]  led,
   input  logic [7:0]  switch,
   output logic [11:0] digi,
   output logic        irqout
);

   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   localparam logic [2:0] OFF_TH      = 3'd0;
   localparam logic [2:0] OFF_TL      = 3'd1;
   localparam logic [2:0] OFF_TCON    = 3'd2;
   localparam logic [2:0] OFF_LED     = 3'd3;
   localparam logic [2:0] OFF_SWITCH  = 3'd4;
   localparam logic [2:0] OFF_DIGI    = 3'd5;
   localparam logic [2:0] OFF_SYSTICK = 3'd6;

   logic [31:0]   r_th;
   logic [31:0]   r_tl;
   logic [2:0]    r_tcon;
   logic [7:0]    r_led;
   logic [11:0]   r_digi;
   logic [PW-1:0] r_pre;

   logic          w_sel;
   logic [2:0]    w_off;
   logic          w_wr;
   logic          w_wr_th;
   logic          w_wr_tl;
   logic          w_wr_tcon;
   logic          w_wr_systick;
   logic          w_tick;
   logic          w_ovf;
   logic          w_irq_set;
   logic [31:0]   w_systick;
   logic          w_unused_addr;

   // Address[27:5] and [1:0] are deliberately not decoded (the map aliases).
   assign w_unused_addr = ^{Address[27:5], Address[1:0]};

   assign w_sel        = (Address[31:28] == 4'h4);
   assign w_off        = Address[4:2];
   assign w_wr         = MemWrite && w_sel;
   assign w_wr_th      = w_wr && (w_off == OFF_TH);
   assign w_wr_tl      = w_wr && (w_off == OFF_TL);
   assign w_wr_tcon    = w_wr && (w_off == OFF_TCON);
   assign w_wr_systick = w_wr && (w_off == OFF_SYSTICK);

   assign w_tick    = r_tcon[0] && (r_pre == PRE_LAST);
   // A CPU write to TL suppresses both the increment and the reload event.
   assign w_ovf     = w_tick && (r_tl == 32'hFFFF_FFFF) && !w_wr_tl;
   assign w_irq_set = w_ovf && r_tcon[1];

   // Prescaler: held at 0 while stopped; TL/TCON writes restart it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre <= '0;
      end else if (!r_tcon[0] || w_wr_tl || w_wr_tcon || w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_th <= '0;
      end else if (w_wr_th) begin
         r_th <= Write_data;
      end
   end

   // On overflow TL reloads from the current TH, so a TH write in the same
   // cycle only takes effect at the following overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tl <= '0;
      end else if (w_wr_tl) begin
         r_tl <= Write_data;
      end else if (w_ovf) begin
         r_tl <= r_th;
      end else if (w_tick) begin
         r_tl <= r_tl + 32'd1;
      end
   end

   // A hardware overflow set always beats a software clear in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tcon <= '0;
      end else if (w_wr_tcon) begin
         r_tcon <= {Write_data[2] | w_irq_set, Write_data[1:0]};
      end else if (w_irq_set) begin
         r_tcon[2] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_led  <= '0;
         r_digi <= '0;
      end else begin
         if (w_wr && (w_off == OFF_LED)) begin
            r_led <= Write_data[7:0];
         end
         if (w_wr && (w_off == OFF_DIGI)) begin
            r_digi <= Write_data[11:0];
         end
      end
   end

   generate
      if (SYSTICK_EN != 0) begin : g_systick
         logic [31:0] r_systick;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_systick <= '0;
            end else if (w_wr_systick) begin
               r_systick <= Write_data;
            end else begin
               r_systick <= r_systick + 32'd1;
            end
         end
         assign w_systick = r_systick;
      end else begin : g_no_systick
         assign w_systick = 32'h0;
      end
   endgenerate

   always_comb begin
      Read_data = 32'h0;
      if (MemRead && w_sel) begin
         case (w_off)
            OFF_TH:      Read_data = r_th;
            OFF_TL:      Read_data = r_tl;
            OFF_TCON:    Read_data = {29'h0, r_tcon};
            OFF_LED:     Read_data = {24'h0, r_led};
            OFF_SWITCH:  Read_data = {24'h0, switch};
            OFF_DIGI:    Read_data = {20'h0, r_digi};
            OFF_SYSTICK: Read_data = w_systick;
            default:     Read_data = 32'h0;
         endcase
      end
   end

   assign led    = r_led;
   assign digi   = r_digi;
   assign irqout = r_tcon[1] & r_tcon[2];

endmodule

// File: tb/tb_timer_peripheral.sv
module tb_timer_peripheral;

   localparam logic [31:0] A_TH      = 32'h4000_0000;
   localparam logic [31:0] A_TL      = 32'h4000_0004;
   localparam logic [31:0] A_TCON    = 32'h4000_0008;
   localparam logic [31:0] A_LED     = 32'h4000_000C;
   localparam logic [31:0] A_SWITCH  = 32'h4000_0010;
   localparam logic [31:0] A_DIGI    = 32'h4000_0014;
   localparam logic [31:0] A_SYSTICK = 32'h4000_0018;
   localparam logic [31:0] A_HOLE    = 32'h4000_001C;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic [7:0]  switch;
   logic [31:0] rd1, rd4;
   logic [7:0]  led1, led4;
   logic [11:0] digi1, digi4;
   logic        irq1, irq4;

   timer_peripheral #(.PRESCALE(1), .SYSTICK_EN(1)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .Write_data(Write_data), .Read_data(rd1),
      .led(led1), .switch(switch), .digi(digi1), .irqout(irq1)
   );

   timer_peripheral #(.PRESCALE(4), .SYSTICK_EN(0)) dut4 (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .Write_data(Write_data), .Read_data(rd4),
      .led(led4), .switch(switch), .digi(digi4), .irqout(irq4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      sb_t e;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, obs, e.exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      MemWrite   = 1'b1;
      Address    = addr;
      Write_data = data;
      cyc(1);
      MemWrite   = 1'b0;
      Address    = 32'h0;
      Write_data = 32'h0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp, input bit use4);
      MemRead = 1'b1;
      Address = addr;
      push_exp(tag, exp);
      #1;
      pop_chk(use4 ? rd4 : rd1);
      MemRead = 1'b0;
      Address = 32'h0;
   endtask

   task automatic pin(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      push_exp(tag, exp);
      pop_chk(obs);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      Address = 32'h0; Write_data = 32'h0; switch = 8'h00;

      // reset
      cyc(2);
      pin("rst_led", {24'h0, led1}, 32'h0);
      pin("rst_digi", {20'h0, digi1}, 32'h0);
      pin("rst_irq", {31'h0, irq1}, 32'h0);
      rd("rst_tl", A_TL, 32'h0, 0);
      rd("rst_th", A_TH, 32'h0, 0);
      rd("rst_tcon", A_TCON, 32'h0, 0);
      reset = 1'b0;
      cyc(1);
      rd("systick_first", A_SYSTICK, 32'd1, 0);
      rd("systick_dis", A_SYSTICK, 32'd0, 1);

      // overflow / reload, PRESCALE=1
      wr(A_TH, 32'hFFFF_FFFC);
      wr(A_TL, 32'hFFFF_FFFE);
      wr(A_TCON, 32'd3);
      cyc(1);
      rd("ovf_tl_max", A_TL, 32'hFFFF_FFFF, 0);
      pin("ovf_irq_pre", {31'h0, irq1}, 32'h0);
      cyc(1);
      rd("ovf_reload", A_TL, 32'hFFFF_FFFC, 0);
      pin("ovf_irq", {31'h0, irq1}, 32'h1);
      wr(A_TCON, 32'd3);
      pin("irq_clear", {31'h0, irq1}, 32'h0);
      rd("tl_after_clr", A_TL, 32'hFFFF_FFFD, 0);
      cyc(2);
      rd("ovf2_max", A_TL, 32'hFFFF_FFFF, 0);
      pin("ovf2_irq_pre", {31'h0, irq1}, 32'h0);
      cyc(1);
      rd("ovf2_reload", A_TL, 32'hFFFF_FFFC, 0);
      pin("ovf2_irq", {31'h0, irq1}, 32'h1);

      // race: TCON write on the overflow edge keeps the interrupt
      wr(A_TCON, 32'd3);
      cyc(2);
      wr(A_TCON, 32'd3);
      pin("race_tcon_irq", {31'h0, irq1}, 32'h1);
      rd("race_tcon_rd", A_TCON, 32'd7, 0);
      rd("race_tcon_tl", A_TL, 32'hFFFF_FFFC, 0);

      // race: TL write on the overflow edge wins
      wr(A_TCON, 32'd3);
      cyc(2);
      rd("race_tl_pre", A_TL, 32'hFFFF_FFFF, 0);
      wr(A_TL, 32'd5);
      rd("race_tl_wr", A_TL, 32'd5, 0);
      cyc(1);
      rd("race_tl_inc", A_TL, 32'd6, 0);

      // race: TH write on the overflow edge -> reload with old TH
      wr(A_TL, 32'hFFFF_FFFE);
      cyc(1);
      wr(A_TH, 32'h10);
      rd("race_th_tl", A_TL, 32'hFFFF_FFFC, 0);
      rd("race_th_th", A_TH, 32'h10, 0);
      cyc(4);
      rd("new_th_reload", A_TL, 32'h10, 0);

      // software interrupt path
      wr(A_TCON, 32'd4);
      pin("sw_irq_noen", {31'h0, irq1}, 32'h0);
      rd("sw_tcon4", A_TCON, 32'd4, 0);
      wr(A_TCON, 32'd6);
      pin("sw_irq_en", {31'h0, irq1}, 32'h1);
      wr(A_TCON, 32'hFFFF_FFF8);
      pin("sw_irq_off", {31'h0, irq1}, 32'h0);
      rd("tcon_hi_zero", A_TCON, 32'd0, 0);

      // PRESCALE=4 instance
      wr(A_TL, 32'd0);
      wr(A_TCON, 32'd1);
      cyc(3);
      rd("ps_3cyc", A_TL, 32'd0, 1);
      cyc(1);
      rd("ps_4cyc", A_TL, 32'd1, 1);
      cyc(4);
      rd("ps_8cyc", A_TL, 32'd2, 1);
      cyc(2);
      wr(A_TCON, 32'd0);
      wr(A_TCON, 32'd1);
      cyc(3);
      rd("ps_restart3", A_TL, 32'd2, 1);
      cyc(1);
      rd("ps_restart4", A_TL, 32'd3, 1);

      // IO registers
      switch = 8'hA5;
      rd("switch", A_SWITCH, 32'h0000_00A5, 0);
      rd("switch_alias", 32'h4ABC_DE13, 32'h0000_00A5, 0);
      wr(A_SWITCH, 32'hFFFF_FFFF);
      rd("switch_ro", A_SWITCH, 32'h0000_00A5, 0);
      wr(A_LED, 32'h1FF);
      pin("led", {24'h0, led1}, 32'hFF);
      wr(A_DIGI, 32'hABC);
      pin("digi", {20'h0, digi1}, 32'hABC);
      rd("digi_rd", A_DIGI, 32'hABC, 0);
      wr(A_HOLE, 32'h1234_5678);
      rd("hole", A_HOLE, 32'h0, 0);
      Address = A_SWITCH;
      MemRead = 1'b0;
      push_exp("no_memread", 32'h0);
      #1;
      pop_chk(rd1);
      rd("wrong_window", 32'h3000_0010, 32'h0, 0);
      wr(A_SYSTICK, 32'd100);
      rd("systick_wr", A_SYSTICK, 32'd100, 0);
      rd("systick_wr_dis", A_SYSTICK, 32'd0, 1);
      cyc(1);
      rd("systick_inc", A_SYSTICK, 32'd101, 0);

      // reset mid-count with a concurrent write
      wr(A_TL, 32'h1234);
      wr(A_TCON, 32'd7);
      pin("pre_rst_irq", {31'h0, irq1}, 32'h1);
      reset      = 1'b1;
      MemWrite   = 1'b1;
      Address    = A_LED;
      Write_data = 32'h55;
      cyc(1);
      reset      = 1'b0;
      MemWrite   = 1'b0;
      Address    = 32'h0;
      Write_data = 32'h0;
      pin("mid_rst_irq", {31'h0, irq1}, 32'h0);
      pin("mid_rst_led", {24'h0, led1}, 32'h0);
      pin("mid_rst_digi", {20'h0, digi1}, 32'h0);
      rd("mid_rst_tl", A_TL, 32'h0, 0);
      rd("mid_rst_th", A_TH, 32'h0, 0);
      rd("mid_rst_tcon", A_TCON, 32'h0, 0);
      rd("mid_rst_systick", A_SYSTICK, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
